fc3_act_packer: RTL and testbench
=================================

# fc3_act_packer

Streaming front end for the final fully connected layer. It accepts one signed pre-activation sum per cycle from the previous layer and requantizes it to a 4-bit signed activation. It packs 32 consecutive activations into the 128-bit vector that `fc3` consumes. Two internal banks let the upstream layer fill one frame while the other is held stable on `m_vec`, and the downstream argmax result is sampled from it.

## Interface
Parameters:
- `IN_W`, default 9: width of the incoming signed sum.
- `SHIFT`, default 2: arithmetic right shift applied during requantization, range 0..6.
- `RELU`, default 1: 1 clamps negative sums to 0 before shifting.

Ports (clock and reset first):
- `clk`  in  1  — the single clock; every register is rising-edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `s_data`  in  IN_W  — signed pre-activation sum.
- `s_valid`  in  1  — `s_data` and `s_last` are valid.
- `s_last`  in  1  — marks the 32nd beat of a frame.
- `s_ready`  out  1  — packer can accept a beat.
- `m_vec`  out  128  — packed frame; lane i occupies bits [4i+3:4i], and lane 0 is the first beat.
- `m_valid`  out  1  — `m_vec` holds a complete frame.
- `m_ready`  in  1  — consumer takes the frame.
- `frame_err`  out  1  — one-cycle pulse when a frame is discarded for bad framing.

## Operation
- Accept: a beat is accepted on `s_valid && s_ready`. Transfers on the master side use `m_valid && m_ready`.
- Requantize each accepted beat as follows:
  - x = RELU ? max(s_data, 0) : s_data.
  - If SHIFT > 0, add 2^(SHIFT-1), computing in IN_W+1 bits so the addition cannot overflow.
  - Arithmetic shift right by SHIFT.
  - Saturate to [-8, 7].
- Banks: bank0 and bank1, each 128 bits with a `full` flag.
  - Pointers are `wr_bank` and `rd_bank`, plus a 5-bit `lane` counter.
  - `s_ready = !full[wr_bank] || state == RESYNC`.
  - `m_valid = full[rd_bank]` and `m_vec = bank[rd_bank]`; both are driven from registers.
- State machine:
  - FILL: an accepted beat writes `lane` of `wr_bank` and increments `lane`.
    - Lane 31 with `s_last`: set `full[wr_bank]`, toggle `wr_bank`, set lane=0.
    - `s_last` on lane < 31 (short frame): discard the partial frame, set lane=0, pulse `frame_err`, stay in FILL.
    - Lane 31 without `s_last` (long frame): discard the frame, set lane=0, pulse `frame_err`, go to RESYNC.
  - RESYNC: accept and drop beats (`s_ready`=1, no writes) until a beat with `s_last` is accepted, then go to FILL. No second `frame_err` is raised.
- Drain: on a master transfer, clear `full[rd_bank]` and toggle `rd_bank`.
- Simultaneous events: commit on `wr_bank` and drain on `rd_bank` in the same cycle are both honoured. When both banks are full, `s_ready`=0 (in FILL) until a drain.
- Reset values:
  - `m_valid`=0, `s_ready`=1, `frame_err`=0, `m_vec`=0.
  - Both banks cleared, pointers 0, lane=0, state FILL.
- Reset mid-frame: the partial frame and any held frames are lost without an error pulse.

## Timing
- Sustained throughput is 1 beat per cycle; 32 beats give one frame every 32 cycles with no bubbles while `m_ready` keeps up.
- Latency: lane-31 beat accepted at edge t gives `m_valid`=1 after edge t, visible in cycle t+1. `fc3` output is valid in the same cycle, because it is combinational.
- `m_vec` is stable while `m_valid`=1 and `m_ready`=0.
- `frame_err` is high for exactly the cycle after the offending beat's acceptance edge.
- Backpressure: if both banks are full, `s_ready` falls in the cycle after the commit. It rises in the cycle after the drain edge.

## Structure
- Shared package `fc_pkg` holds:
  - `LANES`=32, `ACT_W`=4, `VEC_W`=128.
  - The `act_t` typedef (logic signed [3:0]).
  - A `sat_act` function, reused by later quantized layers.
- One sub-module, `act_quant`: combinational requantizer parameterized by `IN_W`, `SHIFT`, `RELU`.
- The FSM, banks and handshake stay in the top level.

## Test plan
- Reset, then 32 beats with s_data=i*4 (SHIFT=2, RELU=1) and `s_last` on beat 31, `m_ready`=1. Required: one `m_valid` pulse with lane i = min(i, 7); `m_vec[3:0]`=0 and `m_vec[127:124]`=7.
- Beats −5, 255, 6, 5 with RELU=1 and SHIFT=2 → 0, 7 (saturated), 2, 1 (round-half-up). Rerun with RELU=0: −5 → −1 and −100 → −8.
- `m_ready`=0 while streaming 96 beats. Required:
  - Two frames held.
  - `s_ready`=0 from beat 64.
  - Raising `m_ready` drains frame A then frame B in order, with `m_vec` unchanged while stalled.
- `s_last` on beat 10. Required:
  - `frame_err` pulses once.
  - No `m_valid`.
  - The next 32-beat frame is packed from lane 0.
- 40 beats without `s_last` followed by one beat with `s_last`. Required:
  - `frame_err` pulses once, at beat 31.
  - All beats up to and including the `s_last` beat are dropped.
  - The following clean frame emits correctly.
- Assert `rst_n`=0 at beat 20 of a frame while one bank is full. Required: `m_valid` falls immediately, and after release a fresh 32-beat frame emits exactly once.

Source files
------------

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants, activation type and saturation helper for the fc layers
package fc_pkg;

  localparam int LANES = 32;
  localparam int ACT_W = 4;
  localparam int VEC_W = 128;

  typedef logic signed [ACT_W-1:0] act_t;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_RESYNC = 1'b1
  } pack_state_e;

  // Clamp a wide signed value into the 4-bit activation range [-8, 7].
  function automatic act_t sat_act(input logic signed [31:0] v);
    if (v > 32'sd7) begin
      return act_t'(4'b0111);
    end else if (v < -32'sd8) begin
      return act_t'(4'b1000);
    end else begin
      return act_t'(v[3:0]);
    end
  endfunction

endpackage

// File: rtl/act_quant.sv
// rtl/act_quant.sv - combinational requantizer from a signed sum to a 4-bit activation
// Ports: din  - signed pre-activation sum (IN_W bits)
//        dout - saturated 4-bit signed activation
module act_quant
  import fc_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int SHIFT = 2,
  parameter int RELU  = 1
) (
  input  logic signed [IN_W-1:0] din,
  output act_t                   dout
);

  // Half of the shift divisor gives round-half-up; zero when SHIFT is 0.
  localparam int RND_I = (1 << SHIFT) >> 1;
  localparam logic signed [IN_W:0] RND = RND_I[IN_W:0];

  // One extra bit of headroom so the rounding add cannot wrap.
  logic signed [IN_W:0] x_ext;
  logic signed [IN_W:0] rounded;
  logic signed [IN_W:0] shifted;

  always_comb begin
    x_ext = {din[IN_W-1], din};
    if (RELU != 0 && din[IN_W-1]) begin
      x_ext = '0;
    end
    rounded = x_ext + RND;
    shifted = rounded >>> SHIFT;
    dout    = sat_act(32'(shifted));
  end

endmodule

// File: rtl/fc3_act_packer.sv
// rtl/fc3_act_packer.sv - requantize and pack 32 activations into double-buffered 128-bit frames
// Ports: clk, rst_n (async active-low)
//        s_data/s_valid/s_last/s_ready - beat stream of signed sums
//        m_vec/m_valid/m_ready         - packed frame output, lane 0 in bits [3:0]
//        frame_err                     - one-cycle pulse when a badly framed frame is dropped
module fc3_act_packer
  import fc_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int SHIFT = 2,
  parameter int RELU  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [IN_W-1:0] s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [VEC_W-1:0]       m_vec,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   frame_err
);

  pack_state_e           state_q, state_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [4:0]            lane_q, lane_d;
  logic [1:0]            full_q, full_d;
  logic [1:0][VEC_W-1:0] bank_q, bank_d;
  logic                  frame_err_q, frame_err_d;

  act_t act;
  logic accept;
  logic drain;

  act_quant #(
    .IN_W (IN_W),
    .SHIFT(SHIFT),
    .RELU (RELU)
  ) u_act_quant (
    .din (s_data),
    .dout(act)
  );

  // In RESYNC beats are swallowed regardless of bank occupancy.
  assign s_ready   = ~full_q[wr_bank_q] | (state_q == ST_RESYNC);
  assign m_valid   = full_q[rd_bank_q];
  assign m_vec     = bank_q[rd_bank_q];
  assign frame_err = frame_err_q;

  assign accept = s_valid & s_ready;
  assign drain  = m_valid & m_ready;

  always_comb begin
    state_d     = state_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    lane_d      = lane_q;
    full_d      = full_q;
    bank_d      = bank_q;
    frame_err_d = 1'b0;

    // A commit can only target a non-full bank and a drain only a full one,
    // so the two never touch the same bank in one cycle.
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end

    if (accept) begin
      if (state_q == ST_FILL) begin
        bank_d[wr_bank_q][{lane_q, 2'b00} +: ACT_W] = act;
        if (lane_q == 5'(LANES - 1)) begin
          lane_d = '0;
          if (s_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_RESYNC;
          end
        end else if (s_last) begin
          lane_d      = '0;
          frame_err_d = 1'b1;
        end else begin
          lane_d = lane_q + 5'd1;
        end
      end else if (s_last) begin
        state_d = ST_FILL;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      lane_q      <= '0;
      full_q      <= '0;
      bank_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      lane_q      <= lane_d;
      full_q      <= full_d;
      bank_q      <= bank_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_fc3_act_packer.sv
// tb/tb_fc3_act_packer.sv - scoreboard bench for fc3_act_packer with RELU=1 and RELU=0 instances
module tb_fc3_act_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic signed [8:0] s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              m_ready = 1'b1;

  logic         s_ready1, m_valid1, frame_err1;
  logic [127:0] m_vec1;
  logic         s_ready0, m_valid0, frame_err0;
  logic [127:0] m_vec0;

  fc3_act_packer #(.IN_W(9), .SHIFT(2), .RELU(1)) u_dut_relu (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready1), .m_vec(m_vec1), .m_valid(m_valid1), .m_ready(m_ready),
    .frame_err(frame_err1)
  );

  fc3_act_packer #(.IN_W(9), .SHIFT(2), .RELU(0)) u_dut_lin (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready0), .m_vec(m_vec0), .m_valid(m_valid0), .m_ready(m_ready),
    .frame_err(frame_err0)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [127:0] q1[$];
  logic [127:0] q0[$];
  logic [127:0] mf1, mf0;
  int  m_lane = 0;
  bit  m_resync = 1'b0;
  int  err_exp = 0;
  int  err_seen1 = 0;
  int  err_seen0 = 0;

  // Reference requantizer: optional ReLU, +2 then floor-divide by 4, clamp to [-8, 7].
  function automatic logic [3:0] qm(input int v, input bit relu);
    int x;
    int r;
    x = (relu && v < 0) ? 0 : v;
    r = (x + 2) >>> 2;
    if (r > 7) r = 7;
    if (r < -8) r = -8;
    return r[3:0];
  endfunction

  task automatic model_accept(input int v, input bit last);
    if (!m_resync) begin
      mf1[m_lane*4 +: 4] = qm(v, 1'b1);
      mf0[m_lane*4 +: 4] = qm(v, 1'b0);
      if (m_lane == 31) begin
        m_lane = 0;
        if (last) begin
          q1.push_back(mf1);
          q0.push_back(mf0);
        end else begin
          err_exp++;
          m_resync = 1'b1;
        end
      end else if (last) begin
        m_lane = 0;
        err_exp++;
      end else begin
        m_lane++;
      end
    end else if (last) begin
      m_resync = 1'b0;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input int v, input bit last);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = 9'(v);
    s_last  = last;
    while (!s_ready1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_val("accept_timeout", 128'd0, 128'd1);
    else model_accept(v, last);
    @(negedge clk);
  endtask

  task automatic idle();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < 32; i++) send(int'($urandom_range(0, 511)) - 256, i == 31);
  endtask

  task automatic settle();
    int n;
    n = 0;
    idle();
    m_ready = 1'b1;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_val("drain_empty", 128'(q1.size() + q0.size()), 128'd0);
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    while (!m_valid1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_val("mvalid_timeout", 128'd0, 128'd1);
  endtask

  // Output monitor: every cycle a frame is presented it must match the scoreboard head,
  // which also covers stability while stalled; the head is retired on a transfer.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (m_valid1) begin
        if (q1.size() == 0) check_val("vec1_unexpected", 128'd1, 128'd0);
        else begin
          check_val("vec1", m_vec1, q1[0]);
          if (m_ready) void'(q1.pop_front());
        end
      end
      if (m_valid0) begin
        if (q0.size() == 0) check_val("vec0_unexpected", 128'd1, 128'd0);
        else begin
          check_val("vec0", m_vec0, q0[0]);
          if (m_ready) void'(q0.pop_front());
        end
      end
      if (frame_err1) err_seen1++;
      if (frame_err0) err_seen0++;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rst_m_valid", 128'(m_valid1), 128'd0);
    check_val("rst_s_ready", 128'(s_ready1), 128'd1);
    check_val("rst_frame_err", 128'(frame_err1), 128'd0);
    check_val("rst_m_vec", m_vec1, 128'd0);
    @(negedge clk);

    // Ramp frame: lane i = min(i, 7).
    for (int i = 0; i < 32; i++) send(i * 4, i == 31);
    check_val("ramp_latency", 128'(m_valid1), 128'd1);
    check_val("ramp_lane0", 128'(m_vec1[3:0]), 128'd0);
    check_val("ramp_lane31", 128'(m_vec1[127:124]), 128'd7);
    settle();

    // Rounding, saturation and ReLU corner values, held for inspection.
    m_ready = 1'b0;
    send(-5, 1'b0); send(255, 1'b0); send(6, 1'b0); send(5, 1'b0); send(-100, 1'b0);
    for (int i = 5; i < 32; i++) send(int'($urandom_range(0, 511)) - 256, i == 31);
    idle();
    wait_mvalid();
    check_val("relu_m5", 128'(m_vec1[3:0]), 128'h0);
    check_val("relu_255", 128'(m_vec1[7:4]), 128'h7);
    check_val("relu_6", 128'(m_vec1[11:8]), 128'h2);
    check_val("relu_5", 128'(m_vec1[15:12]), 128'h1);
    check_val("relu_m100", 128'(m_vec1[19:16]), 128'h0);
    check_val("lin_m5", 128'(m_vec0[3:0]), 128'hF);
    check_val("lin_m100", 128'(m_vec0[19:16]), 128'h8);
    settle();

    // Backpressure: two frames held, third frame stalls until the consumer drains.
    m_ready = 1'b0;
    for (int i = 0; i < 64; i++) send(int'($urandom_range(0, 511)) - 256, (i % 32) == 31);
    check_val("bp_s_ready_low", 128'(s_ready1), 128'd0);
    check_val("bp_m_valid", 128'(m_valid1), 128'd1);
    s_valid = 1'b1;
    s_data  = 9'sd12;
    s_last  = 1'b0;
    repeat (4) @(negedge clk);
    check_val("bp_still_stalled", 128'(s_ready1), 128'd0);
    m_ready = 1'b1;
    send(12, 1'b0);
    for (int i = 65; i < 96; i++) send(int'($urandom_range(0, 511)) - 256, i == 95);
    settle();

    // Short frame: s_last on beat 10.
    for (int i = 0; i < 11; i++) send(i * 8, i == 10);
    check_val("short_err_pulse", 128'(frame_err1), 128'd1);
    idle();
    @(negedge clk);
    check_val("short_err_one_cycle", 128'(frame_err1), 128'd0);
    send_frame();
    settle();

    // Long frame: 40 beats without s_last, then the resync beat, then a clean frame.
    for (int i = 0; i < 40; i++) begin
      send(i, 1'b0);
      if (i == 31) check_val("long_err_at31", 128'(frame_err1), 128'd1);
    end
    send(100, 1'b1);
    check_val("resync_no_err", 128'(frame_err1), 128'd0);
    send_frame();
    settle();
    check_val("err_count_relu", 128'(err_seen1), 128'(err_exp));

    // Reset mid-frame with one bank full.
    m_ready = 1'b0;
    send_frame();
    for (int i = 0; i < 20; i++) send(i, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    check_val("rst_mid_m_valid", 128'(m_valid1), 128'd0);
    q1.delete();
    q0.delete();
    m_lane   = 0;
    m_resync = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    send_frame();
    settle();

    check_val("err_count_relu_final", 128'(err_seen1), 128'(err_exp));
    check_val("err_count_lin_final", 128'(err_seen0), 128'(err_exp));
    check_val("s_ready_match", 128'(s_ready0), 128'(s_ready1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
